// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcode numbering and FSM states.
package alu_pkg;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_AND = 2;
    localparam int unsigned OP_OR  = 3;
    localparam int unsigned OP_SLL = 4;
    localparam int unsigned OP_SRA = 5;
    localparam int unsigned OP_MUL = 6;
    localparam int unsigned OP_DIV = 7;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/alu_iter_core.sv
// Shared iterative datapath: WIDTH-step shift-add multiply or restoring divide
// on operand magnitudes, with the sign applied when the last step completes.
module alu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             mul_ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    logic               busy;
    logic               div_mode;
    logic               negate;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   mq_nxt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] mag;
    logic [2*WIDTH-1:0] signed_full;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    // acc holds the product high half (MUL) or the partial remainder (DIV);
    // mq holds the multiplier bits (MUL) or the dividend/quotient bits (DIV).
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, mag_b};
        shifted = {acc, mq[WIDTH-1]};
        diff    = shifted - {1'b0, mag_b};
        acc_nxt = acc;
        mq_nxt  = mq;
        if (div_mode) begin
            if (shifted >= {1'b0, mag_b}) begin
                acc_nxt = diff[WIDTH-1:0];
                mq_nxt  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[WIDTH-1:0];
                mq_nxt  = {mq[WIDTH-2:0], 1'b0};
            end
        end else if (mq[0]) begin
            acc_nxt = sum[WIDTH:1];
            mq_nxt  = {sum[0], mq[WIDTH-1:1]};
        end else begin
            acc_nxt = {1'b0, acc[WIDTH-1:1]};
            mq_nxt  = {acc[0], mq[WIDTH-1:1]};
        end
    end

    // The result is taken from the post-iteration values so the owner can
    // register it on the same edge as the final step.
    always_comb begin
        done        = busy && (count == CNT_W'(WIDTH - 1));
        mag         = div_mode ? {{WIDTH{1'b0}}, mq_nxt} : {acc_nxt, mq_nxt};
        signed_full = negate ? (~mag + 1'b1) : mag;
        result      = signed_full[WIDTH-1:0];
        mul_ovf     = !div_mode &&
                      !((&signed_full[2*WIDTH-1:WIDTH-1]) || !(|signed_full[2*WIDTH-1:WIDTH-1]));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            div_mode <= 1'b0;
            negate   <= 1'b0;
            count    <= '0;
            acc      <= '0;
            mq       <= '0;
            mag_b    <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            div_mode <= is_div;
            negate   <= a[WIDTH-1] ^ b[WIDTH-1];
            count    <= '0;
            acc      <= '0;
            mq       <= magnitude(a);
            mag_b    <= magnitude(b);
        end else if (busy) begin
            acc   <= acc_nxt;
            mq    <= mq_nxt;
            count <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready on both sides: single-cycle fast ops plus
// WIDTH-cycle signed MUL/DIV, all results and flags held in output registers.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int OPC_W   = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    input  logic [OPC_W-1:0]   ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_result,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               overflow,
    output logic               exception
);

    localparam logic [OPC_W-1:0] OPC_SUB = OPC_W'(OP_SUB);
    localparam logic [OPC_W-1:0] OPC_AND = OPC_W'(OP_AND);
    localparam logic [OPC_W-1:0] OPC_OR  = OPC_W'(OP_OR);
    localparam logic [OPC_W-1:0] OPC_SLL = OPC_W'(OP_SLL);
    localparam logic [OPC_W-1:0] OPC_SRA = OPC_W'(OP_SRA);
    localparam logic [OPC_W-1:0] OPC_MUL = OPC_W'(OP_MUL);
    localparam logic [OPC_W-1:0] OPC_DIV = OPC_W'(OP_DIV);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             is_iter_in;
    logic             is_div_in;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_div;
    logic [WIDTH-1:0] fast_sum;
    logic [WIDTH-1:0] fast_diff;
    logic [WIDTH-1:0] fast_result;
    logic             fast_ovf;
    logic [WIDTH-1:0] iter_result;
    logic             iter_ovf;
    logic             iter_exc;
    logic             core_done;
    logic [WIDTH-1:0] core_result;
    logic             core_mul_ovf;

    assign accept     = in_valid && in_ready;
    assign is_div_in  = (ctrl_ALUopcode == OPC_DIV);
    assign is_iter_in = (ctrl_ALUopcode == OPC_MUL) || is_div_in;

    alu_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .start   (accept && is_iter_in),
        .is_div  (is_div_in),
        .a       (data_operandA),
        .b       (data_operandB),
        .done    (core_done),
        .result  (core_result),
        .mul_ovf (core_mul_ovf)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = is_iter_in ? BUSY : DONE;
            BUSY:    if (core_done) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Unlisted opcodes, including MUL/DIV on this path, fall through to ADD.
    always_comb begin
        fast_sum    = data_operandA + data_operandB;
        fast_diff   = data_operandA - data_operandB;
        fast_result = fast_sum;
        fast_ovf    = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                      (fast_sum[WIDTH-1] != data_operandA[WIDTH-1]);
        case (ctrl_ALUopcode)
            OPC_SUB: begin
                fast_result = fast_diff;
                fast_ovf    = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                              (fast_diff[WIDTH-1] != data_operandA[WIDTH-1]);
            end
            OPC_AND: begin
                fast_result = data_operandA & data_operandB;
                fast_ovf    = 1'b0;
            end
            OPC_OR: begin
                fast_result = data_operandA | data_operandB;
                fast_ovf    = 1'b0;
            end
            OPC_SLL: begin
                fast_result = data_operandA << ctrl_shiftamt;
                fast_ovf    = 1'b0;
            end
            OPC_SRA: begin
                fast_result = $signed(data_operandA) >>> ctrl_shiftamt;
                fast_ovf    = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        iter_result = core_result;
        iter_ovf    = 1'b0;
        iter_exc    = 1'b0;
        if (op_div) begin
            if (op_b == '0) begin
                iter_result = '0;
                iter_exc    = 1'b1;
            end else if ((op_a == MIN_VAL) && (op_b == '1)) begin
                iter_result = MIN_VAL;
                iter_ovf    = 1'b1;
            end
        end else begin
            iter_ovf = core_mul_ovf;
        end
    end

    // Handshake flags track the next state so they come up registered and
    // stay low for as long as reset is held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            data_result <= '0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
            exception   <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_div      <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            if (accept) begin
                op_a   <= data_operandA;
                op_b   <= data_operandB;
                op_div <= is_div_in;
                if (!is_iter_in) begin
                    data_result <= fast_result;
                    isNotEqual  <= (data_operandA != data_operandB);
                    isLessThan  <= ($signed(data_operandA) < $signed(data_operandB));
                    overflow    <= fast_ovf;
                    exception   <= 1'b0;
                end
            end else if ((state == BUSY) && core_done) begin
                data_result <= iter_result;
                isNotEqual  <= (op_a != op_b);
                isLessThan  <= ($signed(op_a) < $signed(op_b));
                overflow    <= iter_ovf;
                exception   <= iter_exc;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at WIDTH=32 and WIDTH=8, checked against
// an integer-arithmetic reference model.
module tb_alu_multicycle;

    typedef struct {
        logic [31:0] result;
        logic        ne;
        logic        lt;
        logic        ovf;
        logic        exc;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic        clock = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        q32[$];
    exp_t        q8[$];
    exp_t        m32;
    exp_t        m8;
    bit          seen32 = 0;
    bit          seen8 = 0;
    int          hold32 = 0;

    logic        rst32, iv32, ir32, ov32, or32, ne32, lt32, ovf32, exc32;
    logic [31:0] a32, b32, res32;
    logic [4:0]  op32, sh32;
    logic        rst8, iv8, ir8, ov8, or8, ne8, lt8, ovf8, exc8;
    logic [7:0]  a8, b8, res8;
    logic [4:0]  op8;
    logic [2:0]  sh8;

    alu_multicycle #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(rst32), .in_valid(iv32), .in_ready(ir32),
        .data_operandA(a32), .data_operandB(b32), .ctrl_ALUopcode(op32),
        .ctrl_shiftamt(sh32), .out_valid(ov32), .out_ready(or32),
        .data_result(res32), .isNotEqual(ne32), .isLessThan(lt32),
        .overflow(ovf32), .exception(exc32)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(rst8), .in_valid(iv8), .in_ready(ir8),
        .data_operandA(a8), .data_operandB(b8), .ctrl_ALUopcode(op8),
        .ctrl_shiftamt(sh8), .out_valid(ov8), .out_ready(or8),
        .data_result(res8), .isNotEqual(ne8), .isLessThan(lt8),
        .overflow(ovf8), .exception(exc8)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endtask

    function automatic exp_t model(int w, int op, logic [31:0] a, logic [31:0] b, int sh);
        exp_t   e;
        longint m, sa, sb, lo, hi, r;
        m  = (longint'(1) << w) - 1;
        hi = m >> 1;
        lo = -hi - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (sa > hi) sa = sa - (m + 1);
        if (sb > hi) sb = sb - (m + 1);
        e.ovf = 1'b0;
        e.exc = 1'b0;
        e.lat = (op == 6 || op == 7) ? w : 0;
        e.acc_cyc = 0;
        case (op)
            1: begin r = sa - sb; e.ovf = (r < lo) || (r > hi); end
            2: r = sa & sb;
            3: r = sa | sb;
            4: r = sa << sh;
            5: r = sa >>> sh;
            6: begin r = sa * sb; e.ovf = (r < lo) || (r > hi); end
            7: begin
                if (sb == 0) begin r = 0; e.exc = 1'b1; end
                else if (sa == lo && sb == -1) begin r = lo; e.ovf = 1'b1; end
                else r = sa / sb;
            end
            default: begin r = sa + sb; e.ovf = (r < lo) || (r > hi); end
        endcase
        e.result = 32'(r & m);
        e.ne = (sa != sb);
        e.lt = (sa < sb);
        return e;
    endfunction

    function automatic logic [31:0] pick(int w);
        logic [31:0] v;
        logic [31:0] msk;
        int          t;
        msk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: begin t = $urandom_range(0, 32); v = 32'(t - 16); end
            2: case ($urandom_range(0, 3))
                   0: v = 32'd1 << (w - 1);
                   1: v = (32'd1 << (w - 1)) - 32'd1;
                   2: v = 32'hFFFF_FFFF;
                   default: v = 32'd0;
               endcase
            default: v = $urandom_range(0, 3);
        endcase
        return v & msk;
    endfunction

    task automatic applyStimulus32(int op, logic [31:0] a, logic [31:0] b, int sh);
        exp_t e;
        int   budget = 0;
        @(negedge clock);
        while (!ir32 && budget < 200) begin @(negedge clock); budget++; end
        if (!ir32) begin
            checks++; failures++;
            $display("[TB] FAIL issue32_timeout in_ready=%0b required=1", ir32);
            return;
        end
        a32 = a; b32 = b; op32 = 5'(op); sh32 = 5'(sh); iv32 = 1'b1;
        e = model(32, op, a, b, sh);
        @(posedge clock); #1;
        e.acc_cyc = cyc;
        q32.push_back(e);
        iv32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 5'($urandom); sh32 = 5'($urandom);
    endtask

    task automatic applyStimulus8(int op, logic [31:0] a, logic [31:0] b, int sh);
        exp_t e;
        int   budget = 0;
        @(negedge clock);
        while (!ir8 && budget < 200) begin @(negedge clock); budget++; end
        if (!ir8) begin
            checks++; failures++;
            $display("[TB] FAIL issue8_timeout in_ready=%0b required=1", ir8);
            return;
        end
        a8 = a[7:0]; b8 = b[7:0]; op8 = 5'(op); sh8 = 3'(sh); iv8 = 1'b1;
        e = model(8, op, a, b, sh);
        @(posedge clock); #1;
        e.acc_cyc = cyc;
        q8.push_back(e);
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 5'($urandom); sh8 = 3'($urandom);
    endtask

    always @(negedge clock) begin
        if (ov32) begin
            if (q32.size() == 0) begin
                checks++; failures++;
                $display("[TB] FAIL out32_unexpected out_valid=1 required=0");
            end else begin
                m32 = q32[0];
                if (!seen32) begin
                    check("lat32", 64'(cyc - m32.acc_cyc), 64'(m32.lat));
                    seen32 = 1;
                end
                check("res32", res32, m32.result);
                check("ne32", ne32, m32.ne);
                check("lt32", lt32, m32.lt);
                check("ovf32", ovf32, m32.ovf);
                check("exc32", exc32, m32.exc);
                check("inready_busy32", ir32, 0);
            end
        end
        if (ov32 && hold32 > 0) begin
            or32 = 1'b0;
            hold32--;
        end else begin
            or32 = ($urandom_range(0, 3) != 0);
        end
        if (ov32 && or32 && q32.size() > 0) begin
            void'(q32.pop_front());
            seen32 = 0;
        end
    end

    always @(negedge clock) begin
        if (ov8) begin
            if (q8.size() == 0) begin
                checks++; failures++;
                $display("[TB] FAIL out8_unexpected out_valid=1 required=0");
            end else begin
                m8 = q8[0];
                if (!seen8) begin
                    check("lat8", 64'(cyc - m8.acc_cyc), 64'(m8.lat));
                    seen8 = 1;
                end
                check("res8", res8, m8.result);
                check("ne8", ne8, m8.ne);
                check("lt8", lt8, m8.lt);
                check("ovf8", ovf8, m8.ovf);
                check("exc8", exc8, m8.exc);
            end
        end
        or8 = ($urandom_range(0, 2) != 0);
        if (ov8 && or8 && q8.size() > 0) begin
            void'(q8.pop_front());
            seen8 = 0;
        end
    end

    task automatic checkOutput32Zero(string tag);
        check({tag, "_in_ready"}, ir32, 0);
        check({tag, "_out_valid"}, ov32, 0);
        check({tag, "_result"}, res32, 0);
        check({tag, "_flags"}, {ne32, lt32, ovf32, exc32}, 0);
    endtask

    task automatic drain(int which);
        int budget = 0;
        while (((which == 32) ? q32.size() : q8.size()) != 0 && budget < 1000) begin
            @(negedge clock);
            budget++;
        end
        if (((which == 32) ? q32.size() : q8.size()) != 0) begin
            checks++; failures++;
            $display("[TB] FAIL drain%0d_timeout pending=%0d required=0", which,
                     (which == 32) ? q32.size() : q8.size());
        end
    endtask

    initial begin
        rst32 = 1'b0; rst8 = 1'b0;
        iv32 = 1'b0; a32 = '0; b32 = '0; op32 = '0; sh32 = '0;
        iv8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; sh8 = '0;
        #12;
        checkOutput32Zero("reset");
        check("reset8_in_ready", ir8, 0);
        repeat (2) @(negedge clock);
        rst32 = 1'b1; rst8 = 1'b1;
        @(posedge clock); #1;
        check("post_reset_in_ready", ir32, 1);

        applyStimulus32(0, 32'h7FFF_FFFF, 32'h1, 0);
        drain(32);
        hold32 = 5;
        applyStimulus32(5, 32'h8000_0000, 32'h1234_5678, 4);
        applyStimulus32(6, 32'hFFFF_FFF9, 32'd6, 0);
        applyStimulus32(6, 32'h0001_0000, 32'h0001_0000, 0);
        applyStimulus32(7, 32'hFFFF_FFF9, 32'd2, 0);
        applyStimulus32(7, 32'd12345, 32'd0, 0);
        applyStimulus32(7, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        applyStimulus32(1, 32'h8000_0000, 32'd1, 0);
        applyStimulus32(4, 32'h0000_0003, 32'd0, 31);
        applyStimulus32(9, 32'd3, 32'd4, 0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus32($urandom_range(0, 9), pick(32), pick(32), $urandom_range(0, 31));
        end
        drain(32);

        applyStimulus32(6, 32'd1234, 32'hFFFF_FF00, 0);
        repeat (10) @(posedge clock);
        #2;
        rst32 = 1'b0;
        #1;
        checkOutput32Zero("abort");
        q32.delete();
        seen32 = 0;
        repeat (2) @(negedge clock);
        rst32 = 1'b1;
        @(posedge clock); #1;
        check("abort_release_in_ready", ir32, 1);
        applyStimulus32(0, 32'd2, 32'd3, 0);
        drain(32);

        applyStimulus8(6, 32'd12, 32'hF5, 0);
        applyStimulus8(9, 32'd3, 32'd4, 0);
        applyStimulus8(7, 32'h80, 32'hFF, 0);
        for (int i = 0; i < 25; i++) begin
            applyStimulus8($urandom_range(0, 9), pick(8), pick(8), $urandom_range(0, 7));
        end
        drain(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
